// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: merges the ALU stream with a FIFO of long-latency results and keeps the pending-write scoreboard.
// Optional ALU starvation guard is enabled by defining WB_STARVE_GUARD_EN.
module wb_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        hazard,
  output logic [31:0] busy,
  output logic        alu_stall,
  output logic        we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t     fifo_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   busy_q, busy_d;
  logic          we_q, we_d;
  logic [4:0]    rd_addr_q, rd_addr_d;
  logic [31:0]   rd_data_q, rd_data_d;

  logic      fifo_empty;
  logic      enq;
  logic      alu_win;
  logic      pop;
  wb_entry_t head;

  assign fifo_empty = (count_q == '0);
  assign mem_ready  = (count_q != CW'(DEPTH));
  assign enq        = mem_valid & mem_ready;
  assign alu_win    = alu_valid & ~alu_stall;
  assign pop        = ~alu_win & ~fifo_empty;
  assign head       = fifo_mem_q[rd_ptr_q];

  // NOTE: the FIFO payload has no reset; the pointers and count define which
  // entries are valid, so clearing the storage would only cost reset routing.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_mem_q[wr_ptr_q] <= '{rd: mem_rd, data: mem_data};
    end
  end

  // NOTE: every always_comb output is given its hold value first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({enq, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Winner loads the write port; rd 0 results are consumed without a write.
  always_comb begin
    we_d      = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (alu_win) begin
      we_d      = (alu_rd != 5'd0);
      rd_addr_d = alu_rd;
      rd_data_d = alu_data;
    end else if (pop) begin
      we_d      = (head.rd != 5'd0);
      rd_addr_d = head.rd;
      rd_data_d = head.data;
    end
  end

  // Issue is applied after the pop so a same-cycle set wins over the clear.
  always_comb begin
    busy_d = busy_q;
    if (pop)         busy_d[head.rd]  = 1'b0;
    if (issue_valid) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      busy_q    <= '0;
      we_q      <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      we_q      <= we_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;

  // Counts consecutive cycles the ALU beat a waiting FIFO head.
  assign alu_stall = (starve_q == SW'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) starve_d = '0;
    else if (alu_win)      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  logic unused_starve_max;

  assign unused_starve_max = ^STARVE_MAX;
  assign alu_stall         = 1'b0;
`endif

  assign busy    = busy_q;
  assign hazard  = busy_q[rs1_addr] | busy_q[rs2_addr];
  assign we      = we_q;
  assign rd_addr = rd_addr_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register-file writes are queued by the
// stimulus and consumed by an independent monitor whenever we is asserted.
module tb_wb_arbiter;

`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        hazard;
  logic [31:0] busy;
  logic        alu_stall;
  logic        we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .hazard(hazard), .busy(busy), .alu_stall(alu_stall),
    .we(we), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every asserted write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {27'd0, rd_addr}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_rd_addr", {27'd0, rd_addr}, {27'd0, e.rd});
        check("wb_rd_data", rd_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
    cyc(); cyc();
    check("reset_we",        {31'd0, we},        32'd0);
    check("reset_busy",      busy,               32'd0);
    check("reset_mem_ready", {31'd0, mem_ready}, 32'd1);
    check("reset_hazard",    {31'd0, hazard},    32'd0);
    check("reset_alu_stall", {31'd0, alu_stall}, 32'd0);
    check("reset_rd_data",   rd_data,            32'd0);
    rst = 1'b0;
    cyc();

    // ALU write, 1-cycle latency, then idle hold.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    expect_write(5'd5, 32'hDEAD_BEEF);
    cyc();
    alu_valid = 1'b0;
    check("alu_we", {31'd0, we}, 32'd1);
    cyc();
    check("idle_we",        {31'd0, we},      32'd0);
    check("idle_hold_addr", {27'd0, rd_addr}, 32'd5);
    check("idle_hold_data", rd_data,          32'hDEAD_BEEF);

    // Scoreboard and hazard, then the matching long-latency result.
    issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7;
    #1;
    check("hazard_same_cycle", {31'd0, hazard}, 32'd0);
    cyc();
    issue_valid = 1'b0;
    #1;
    check("hazard_rs1", {31'd0, hazard}, 32'd1);
    check("busy_set",   busy,            32'h0000_0080);
    rs1_addr = 5'd0; rs2_addr = 5'd7;
    #1;
    check("hazard_rs2", {31'd0, hazard}, 32'd1);
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h0000_1234;
    expect_write(5'd7, 32'h0000_1234);
    cyc();
    mem_valid = 1'b0;
    check("mem_lat_we_early", {31'd0, we}, 32'd0);
    check("mem_busy_pending", busy,        32'h0000_0080);
    cyc();
    check("mem_lat_we",   {31'd0, we},     32'd1);
    check("mem_busy_clr", busy,            32'd0);
    check("mem_hazard",   {31'd0, hazard}, 32'd0);
    rs2_addr = 5'd0;

    // Fill the FIFO behind a continuous ALU stream, then drain in order.
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA000_0000 + i;
      mem_valid = 1'b1; mem_rd = 5'(11 + i); mem_data = 32'h0000_1000 + i;
      expect_write(5'd10, 32'hA000_0000 + i);
      cyc();
    end
    check("full_mem_ready", {31'd0, mem_ready}, 32'd0);
    alu_valid = 1'b0; mem_valid = 1'b0;
    for (int i = 0; i < 4; i++) expect_write(5'(11 + i), 32'h0000_1000 + i);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("drain_we", {31'd0, we}, 32'd1);
      if (i == 0) check("drain_mem_ready", {31'd0, mem_ready}, 32'd1);
    end

    // rd 0 results: never written, but the FIFO entry is consumed.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_0055;
    cyc();
    check("alu_rd0_we", {31'd0, we}, 32'd0);
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h0000_0066;
    cyc();
    mem_valid = 1'b0;
    cyc();
    check("mem_rd0_we", {31'd0, we}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hBB00_0000 + i;
      mem_valid = 1'b1; mem_rd = 5'(23 + i); mem_data = 32'hC000_0000 + i;
      expect_write(5'd20, 32'hBB00_0000 + i);
      cyc();
    end
    check("rd0_count_dec", {31'd0, mem_ready}, 32'd1);
    alu_valid = 1'b0; mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) expect_write(5'(23 + i), 32'hC000_0000 + i);
    for (int i = 0; i < 3; i++) cyc();

    // Starvation: one entry behind a constant ALU stream.
    issue_valid = 1'b1; issue_rd = 5'd22;
    mem_valid = 1'b1; mem_rd = 5'd22; mem_data = 32'h0000_CAFE;
    alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'hF000_0000;
    expect_write(5'd21, 32'hF000_0000);
    cyc();
    issue_valid = 1'b0; mem_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      alu_data = 32'hF000_0000 + k;
      #1;
      check("starve_alu_stall", {31'd0, alu_stall}, {31'd0, (GUARD && k == 9)});
      if (GUARD && k == 9) expect_write(5'd22, 32'h0000_CAFE);
      else                 expect_write(5'd21, 32'hF000_0000 + k);
      cyc();
    end
    check("starve_busy", busy, GUARD ? 32'd0 : 32'h0040_0000);
    alu_valid = 1'b0;
    if (!GUARD) expect_write(5'd22, 32'h0000_CAFE);
    cyc();
    check("starve_final_busy", busy, 32'd0);

    // Reset mid-operation discards the queued entry and its pending bit.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h0000_0077;
    issue_valid = 1'b1; issue_rd = 5'd3;
    cyc();
    mem_valid = 1'b0; issue_valid = 1'b0; alu_valid = 1'b0;
    check("pre_reset_busy", busy, 32'h0000_0008);
    rst = 1'b1;
    cyc();
    check("midrst_busy",      busy,               32'd0);
    check("midrst_mem_ready", {31'd0, mem_ready}, 32'd1);
    check("midrst_we",        {31'd0, we},        32'd0);
    rst = 1'b0;
    cyc(); cyc();
    check("post_reset_we", {31'd0, we}, 32'd0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
